// File: rtl/regfile_pkg.sv
// Shared constants for the register file with load scoreboard.
package regfile_pkg;
    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_ZERO_IDX = 0;
endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for outstanding loads plus a registered count of busy registers.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic              busy0,
    output logic              busy1,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              wren,
    input  logic [ADDR_W-1:0] ldaddr,
    input  logic              ldwren,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              iss_valid,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int   DEPTH = 1 << ADDR_W;
    localparam logic ZR    = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(RF_ZERO_IDX);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [ADDR_W:0]  r_cnt;
    logic [ADDR_W:0]  w_cnt_nxt;
    logic             w_set;
    logic             w_clr_a;
    logic             w_clr_b;
    logic             w_inc;
    logic             w_dec_a;
    logic             w_dec_b;

    // Qualify set/clear events; the zero register never takes part when hard-wired.
    always_comb begin
        w_set   = iss_valid && !(ZR && (iss_addr == ZIDX));
        w_clr_a = wren      && !(ZR && (waddr    == ZIDX));
        w_clr_b = ldwren    && !(ZR && (ldaddr   == ZIDX));
    end

    // Next busy vector: a write clears its bit, a same-cycle issue to that bit wins.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_set && (iss_addr == ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end else if ((w_clr_a && (waddr == ADDR_W'(i))) ||
                         (w_clr_b && (ldaddr == ADDR_W'(i)))) begin
                w_busy_nxt[i] = 1'b0;
            end else begin
                w_busy_nxt[i] = r_busy[i];
            end
        end
    end

    // Count delta: only real 0->1 and 1->0 transitions move the count. Two distinct
    // write ports can retire two busy registers at once, so a -2 step is possible.
    always_comb begin
        w_inc   = w_set && !r_busy[iss_addr];
        w_dec_a = w_clr_a && r_busy[waddr] && !(w_set && (iss_addr == waddr));
        w_dec_b = w_clr_b && r_busy[ldaddr] && !(w_set && (iss_addr == ldaddr))
                  && !(w_clr_a && (waddr == ldaddr));
        w_cnt_nxt = r_cnt + {{ADDR_W{1'b0}}, w_inc}
                          - {{ADDR_W{1'b0}}, w_dec_a}
                          - {{ADDR_W{1'b0}}, w_dec_b};
    end

    // Busy vector and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= {DEPTH{1'b0}};
            r_cnt  <= {(ADDR_W+1){1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    // Read-side busy: a same-cycle load completion is bypassed, so the reader sees it ready.
    always_comb begin
        busy0 = r_busy[raddr0] && !(ldwren && (ldaddr == raddr0));
        busy1 = r_busy[raddr1] && !(ldwren && (ldaddr == raddr1));
    end

    assign pend_cnt = r_cnt;
endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read, two-write register file with write-to-read bypass and a load scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy0,
    output logic              busy1,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wren,
    input  logic [ADDR_W-1:0] ldaddr,
    input  logic [DATA_W-1:0] lddata,
    input  logic              ldwren,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              iss_valid,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int   DEPTH = 1 << ADDR_W;
    localparam logic ZR    = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(RF_ZERO_IDX);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_a;
    logic              w_wr_b;

    // Writes to the hard-wired zero register are dropped.
    always_comb begin
        w_wr_a = wren   && !(ZR && (waddr  == ZIDX));
        w_wr_b = ldwren && !(ZR && (ldaddr == ZIDX));
    end

    // Data array; port A is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (w_wr_b) begin
                r_mem[ldaddr] <= lddata;
            end
            if (w_wr_a) begin
                r_mem[waddr] <= wdata;
            end
        end
    end

    // Read port 0: zero register, then port A bypass, then port B bypass, then array.
    always_comb begin
        if (ZR && (raddr0 == ZIDX)) begin
            rdata0 = {DATA_W{1'b0}};
        end else if (wren && (waddr == raddr0)) begin
            rdata0 = wdata;
        end else if (ldwren && (ldaddr == raddr0)) begin
            rdata0 = lddata;
        end else begin
            rdata0 = r_mem[raddr0];
        end
    end

    // Read port 1: same priority as port 0.
    always_comb begin
        if (ZR && (raddr1 == ZIDX)) begin
            rdata1 = {DATA_W{1'b0}};
        end else if (wren && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else if (ldwren && (ldaddr == raddr1)) begin
            rdata1 = lddata;
        end else begin
            rdata1 = r_mem[raddr1];
        end
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .raddr0    (raddr0),
        .raddr1    (raddr1),
        .busy0     (busy0),
        .busy1     (busy1),
        .waddr     (waddr),
        .wren      (wren),
        .ldaddr    (ldaddr),
        .ldwren    (ldwren),
        .iss_addr  (iss_addr),
        .iss_valid (iss_valid),
        .pend_cnt  (pend_cnt)
    );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: stimulus pushes expected outputs, a monitor pops and compares.
module tb_regfile_scoreboard;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] raddr0, raddr1, waddr, ldaddr, iss_addr;
    logic [DW-1:0] rdata0, rdata1, wdata, lddata;
    logic          busy0, busy1, wren, ldwren, iss_valid;
    logic [AW:0]   pend_cnt;

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(rdata0), .rdata1(rdata1), .busy0(busy0), .busy1(busy1),
        .waddr(waddr), .wdata(wdata), .wren(wren),
        .ldaddr(ldaddr), .lddata(lddata), .ldwren(ldwren),
        .iss_addr(iss_addr), .iss_valid(iss_valid), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        logic          b0;
        logic          b1;
        logic [AW:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: plain arrays following the architectural rules.
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];

    function automatic int m_pending();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [DW-1:0] m_read(input int a);
        if (a == 0) return '0;
        if (wren && int'(waddr) == a) return wdata;
        if (ldwren && int'(ldaddr) == a) return lddata;
        return m_mem[a];
    endfunction

    function automatic bit m_rbusy(input int a);
        if (ldwren && int'(ldaddr) == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic m_edge();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (ldwren && ldaddr != 0) begin
                m_mem[ldaddr] = lddata;
                m_busy[ldaddr] = 1'b0;
            end
            if (wren && waddr != 0) begin
                m_mem[waddr] = wdata;
                m_busy[waddr] = 1'b0;
            end
            if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
    endtask

    task automatic idle();
        rst = 1'b0; wren = 1'b0; ldwren = 1'b0; iss_valid = 1'b0;
    endtask

    // Push the expectation for the current inputs, then advance one clock.
    task automatic cycle(input string tag);
        exp_t e;
        e.tag = tag;
        e.rd0 = m_read(int'(raddr0));
        e.rd1 = m_read(int'(raddr1));
        e.b0  = m_rbusy(int'(raddr0));
        e.b1  = m_rbusy(int'(raddr1));
        e.cnt = (AW+1)'(m_pending());
        exp_q.push_back(e);
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic chk(input string tag, input string fld, input logic [DW-1:0] got,
                       input logic [DW-1:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s %s got=%h required=%h", tag, fld, got, req);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.tag, "rdata0", rdata0, e.rd0);
                chk(e.tag, "rdata1", rdata1, e.rd1);
                chk(e.tag, "busy0", {31'd0, busy0}, {31'd0, e.b0});
                chk(e.tag, "busy1", {31'd0, busy1}, {31'd0, e.b1});
                chk(e.tag, "pend_cnt", {26'd0, pend_cnt}, {26'd0, e.cnt});
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_busy[i] = 1'b0;
        end
        idle();
        raddr0 = '0; raddr1 = '0; waddr = '0; ldaddr = '0; iss_addr = '0;
        wdata = '0; lddata = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; cycle("reset");
        idle(); raddr0 = 5'd5; raddr1 = 5'd31; cycle("post_reset");

        // Write reg5 via A with same-cycle bypass, then read next cycle.
        wren = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; cycle("bypass_a");
        idle(); cycle("read_reg5");

        // Both ports hit reg7: A data is kept.
        wren = 1'b1; waddr = 5'd7; wdata = 32'h1111;
        ldwren = 1'b1; ldaddr = 5'd7; lddata = 32'h2222;
        raddr1 = 5'd7; cycle("ab_same_cycle");
        idle(); cycle("read_reg7");

        // Zero register ignores writes and issues.
        wren = 1'b1; waddr = 5'd0; wdata = 32'h55;
        ldwren = 1'b1; ldaddr = 5'd0; lddata = 32'h55;
        iss_valid = 1'b1; iss_addr = 5'd0; raddr0 = 5'd0; cycle("zero_write");
        idle(); cycle("zero_read");

        // Two outstanding loads, one completes via B.
        iss_valid = 1'b1; iss_addr = 5'd3; cycle("issue3");
        iss_addr = 5'd4; cycle("issue4");
        idle(); raddr0 = 5'd3; raddr1 = 5'd4; cycle("two_busy");
        ldwren = 1'b1; ldaddr = 5'd3; lddata = 32'hAB; cycle("complete3");
        idle(); cycle("after_complete3");

        // Issue and completion of reg9 in one cycle: set wins; re-issue does not count.
        iss_valid = 1'b1; iss_addr = 5'd9; raddr0 = 5'd9; cycle("issue9");
        ldwren = 1'b1; ldaddr = 5'd9; lddata = 32'h99; cycle("issue_complete9");
        idle(); cycle("after9");
        iss_valid = 1'b1; iss_addr = 5'd9; cycle("reissue9");
        idle(); cycle("after_reissue9");

        // Reset in the middle of outstanding loads with a write active.
        iss_valid = 1'b1; iss_addr = 5'd12; cycle("issue12");
        idle(); raddr0 = 5'd12; raddr1 = 5'd5;
        rst = 1'b1; wren = 1'b1; waddr = 5'd5; wdata = 32'hCAFE;
        iss_valid = 1'b1; iss_addr = 5'd20; cycle("mid_reset");
        idle(); cycle("after_mid_reset");
        raddr0 = 5'd7; raddr1 = 5'd9; cycle("after_mid_reset2");

        // Randomized traffic, biased to a small address window for collisions.
        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] lim;
            lim = ($urandom_range(0, 1) == 0) ? 5'd7 : 5'd31;
            rst       = ($urandom_range(0, 99) < 2);
            wren      = ($urandom_range(0, 99) < 40);
            ldwren    = ($urandom_range(0, 99) < 40);
            iss_valid = ($urandom_range(0, 99) < 45);
            waddr     = AW'($urandom_range(0, int'(lim)));
            ldaddr    = AW'($urandom_range(0, int'(lim)));
            iss_addr  = AW'($urandom_range(0, int'(lim)));
            raddr0    = AW'($urandom_range(0, int'(lim)));
            raddr1    = AW'($urandom_range(0, int'(lim)));
            wdata     = $urandom;
            lddata    = $urandom;
            cycle("random");
        end
        idle();
        @(negedge clk); #1;

        chk("drain", "queue_left", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
